// File: rtl/start_sequence_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : start_sequence_ctrl_if
// Brief    : Key/PRBS inputs and LED/display outputs of the start sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface start_sequence_ctrl_if #(
    parameter int N_LEDS  = 10,
    parameter int PRBS_W  = 8,
    parameter int REACT_W = 14
);
    logic                i_tick;
    logic                i_start;
    logic                i_press;
    logic [PRBS_W-1:0]   i_prbs;
    logic                o_prbsEn;
    logic [N_LEDS-1:0]   o_turnOnLED;
    logic                o_go;
    logic                o_busy;
    logic [REACT_W-1:0]  o_reactionMs;
    logic                o_valid;
    logic                o_falseStart;
    logic                o_timeout;
    logic [REACT_W-1:0]  o_bestMs;

    modport master (
        output i_tick, i_start, i_press, i_prbs,
        input  o_prbsEn, o_turnOnLED, o_go, o_busy, o_reactionMs,
               o_valid, o_falseStart, o_timeout, o_bestMs
    );

    modport slave (
        input  i_tick, i_start, i_press, i_prbs,
        output o_prbsEn, o_turnOnLED, o_go, o_busy, o_reactionMs,
               o_valid, o_falseStart, o_timeout, o_bestMs
    );
endinterface
`default_nettype wire

// File: rtl/start_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : start_sequence_ctrl
// Brief    : Reaction-game sequencer: LED countdown, random hold, reaction timing.
// Revision : 1.0 - initial release
// ============================================================================
module start_sequence_ctrl #(
    parameter int N_LEDS     = 10,
    parameter int STEP_TICKS = 100,
    parameter int PRBS_W     = 8,
    parameter int DELAY_MIN  = 500,
    parameter int REACT_W    = 14,
    parameter int REACT_MAX  = 9999
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    start_sequence_ctrl_if.slave bus
);
    localparam int c_led_w  = $clog2(N_LEDS + 1);
    localparam int c_step_w = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    localparam logic [c_led_w-1:0]  c_led_last   = c_led_w'(N_LEDS - 1);
    localparam logic [c_step_w-1:0] c_step_last  = c_step_w'(STEP_TICKS - 1);
    localparam logic [15:0]         c_delay_min  = 16'(DELAY_MIN);
    localparam logic [REACT_W-1:0]  c_react_max  = REACT_W'(REACT_MAX);
    localparam logic [REACT_W-1:0]  c_react_last = REACT_W'(REACT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LIGHTS = 3'd1,
        S_HOLD   = 3'd2,
        S_GO     = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t               r_state,       w_state_nxt;
    logic [c_led_w-1:0]   r_led_cnt,     w_led_nxt;
    logic [c_step_w-1:0]  r_step_cnt,    w_step_nxt;
    logic [15:0]          r_dly,         w_dly_nxt;
    logic [REACT_W-1:0]   r_react_cnt,   w_react_nxt;
    logic [REACT_W-1:0]   r_reaction_ms, w_reaction_nxt;
    logic [REACT_W-1:0]   r_best_ms,     w_best_nxt;
    logic                 r_valid,       w_valid_nxt;
    logic                 r_false_start, w_false_nxt;
    logic                 r_timeout,     w_timeout_nxt;

    logic                 w_prbs_en;
    logic [N_LEDS-1:0]    w_leds;
    logic                 w_go;
    logic                 w_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_led_cnt     <= '0;
            r_step_cnt    <= '0;
            r_dly         <= '0;
            r_react_cnt   <= '0;
            r_reaction_ms <= '0;
            r_best_ms     <= c_react_max;
            r_valid       <= 1'b0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_led_cnt     <= w_led_nxt;
            r_step_cnt    <= w_step_nxt;
            r_dly         <= w_dly_nxt;
            r_react_cnt   <= w_react_nxt;
            r_reaction_ms <= w_reaction_nxt;
            r_best_ms     <= w_best_nxt;
            r_valid       <= w_valid_nxt;
            r_false_start <= w_false_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_led_nxt      = r_led_cnt;
        w_step_nxt     = r_step_cnt;
        w_dly_nxt      = r_dly;
        w_react_nxt    = r_react_cnt;
        w_reaction_nxt = r_reaction_ms;
        w_best_nxt     = r_best_ms;
        w_valid_nxt    = 1'b0;
        w_false_nxt    = r_false_start;
        w_timeout_nxt  = r_timeout;

        case (r_state)
            S_IDLE, S_RESULT: begin
                if (bus.i_start) begin
                    w_state_nxt   = S_LIGHTS;
                    w_led_nxt     = '0;
                    w_step_nxt    = '0;
                    w_false_nxt   = 1'b0;
                    w_timeout_nxt = 1'b0;
                end
            end
            S_LIGHTS: begin
                if (bus.i_press) begin
                    w_state_nxt = S_RESULT;
                    w_false_nxt = 1'b1;
                end else if (bus.i_tick) begin
                    if (r_step_cnt == c_step_last) begin
                        w_step_nxt = '0;
                        w_led_nxt  = r_led_cnt + 1'b1;
                        if (r_led_cnt == c_led_last) begin
                            w_state_nxt = S_HOLD;
                            w_dly_nxt   = c_delay_min + 16'(bus.i_prbs);
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (bus.i_press) begin
                    w_state_nxt = S_RESULT;
                    w_false_nxt = 1'b1;
                end else if (bus.i_tick) begin
                    // dly is at least 1 on entry, so it stops at 1 and never wraps
                    if (r_dly == 16'd1) begin
                        w_state_nxt = S_GO;
                        w_react_nxt = '0;
                    end else begin
                        w_dly_nxt = r_dly - 16'd1;
                    end
                end
            end
            S_GO: begin
                if (bus.i_press) begin
                    w_state_nxt    = S_RESULT;
                    w_reaction_nxt = r_react_cnt;
                    w_valid_nxt    = 1'b1;
                    if (r_react_cnt < r_best_ms) begin
                        w_best_nxt = r_react_cnt;
                    end
                end else if (bus.i_tick) begin
                    if (r_react_cnt == c_react_last) begin
                        w_state_nxt    = S_RESULT;
                        w_timeout_nxt  = 1'b1;
                        w_reaction_nxt = c_react_max;
                    end else begin
                        w_react_nxt = r_react_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_prbs_en = (r_state == S_IDLE) || (r_state == S_LIGHTS) || (r_state == S_RESULT);
        w_go      = (r_state == S_GO);
        w_busy    = (r_state == S_LIGHTS) || (r_state == S_HOLD) || (r_state == S_GO);
        w_leds    = '0;
        if (r_state == S_LIGHTS) begin
            for (int i = 0; i < N_LEDS; i++) begin
                w_leds[i] = (r_led_cnt > c_led_w'(i));
            end
        end else if (r_state == S_HOLD) begin
            w_leds = '1;
        end
    end

    assign bus.o_prbsEn     = w_prbs_en;
    assign bus.o_turnOnLED  = w_leds;
    assign bus.o_go         = w_go;
    assign bus.o_busy       = w_busy;
    assign bus.o_reactionMs = r_reaction_ms;
    assign bus.o_valid      = r_valid;
    assign bus.o_falseStart = r_false_start;
    assign bus.o_timeout    = r_timeout;
    assign bus.o_bestMs     = r_best_ms;
endmodule
`default_nettype wire

// File: tb/tb_start_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_start_sequence_ctrl
// Brief    : Randomised rounds against a tick-count model, scoreboarded results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_start_sequence_ctrl;
    localparam int N_LEDS     = 10;
    localparam int STEP_TICKS = 2;
    localparam int PRBS_W     = 8;
    localparam int DELAY_MIN  = 5;
    localparam int REACT_W    = 14;
    localparam int REACT_MAX  = 50;
    localparam int L_TICKS    = N_LEDS * STEP_TICKS;
    localparam int K_VALID    = 0;
    localparam int K_FALSE    = 1;
    localparam int K_TIMEOUT  = 2;

    typedef struct {
        int kind;
        int react;
        int best;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    start_sequence_ctrl_if #(.N_LEDS(N_LEDS), .PRBS_W(PRBS_W), .REACT_W(REACT_W)) sif ();

    start_sequence_ctrl #(
        .N_LEDS     (N_LEDS),
        .STEP_TICKS (STEP_TICKS),
        .PRBS_W     (PRBS_W),
        .DELAY_MIN  (DELAY_MIN),
        .REACT_W    (REACT_W),
        .REACT_MAX  (REACT_MAX)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sif.slave)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   m_react     = 0;
    int   m_best      = REACT_MAX;
    bit   abort       = 1'b0;
    bit   busy_prev   = 1'b0;
    bit   chk_valid_lo = 1'b0;
    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit next_tick();
        next_tick = (cyc % 4 == 0);
        cyc++;
    endfunction

    task automatic step(input bit t, input bit s, input bit p);
        sif.i_tick  = t;
        sif.i_start = s;
        sif.i_press = p;
        @(posedge clk);
        #1;
        sif.i_tick  = 1'b0;
        sif.i_start = 1'b0;
        sif.i_press = 1'b0;
    endtask

    // Expected display state purely from ticks counted since start (no press yet)
    task automatic chk_state(input int n, input int tgo);
        int leds, flags;
        if (n < L_TICKS) begin
            leds = (1 << (n / STEP_TICKS)) - 1; flags = 3'b011;
        end else if (n < tgo) begin
            leds = (1 << N_LEDS) - 1;           flags = 3'b010;
        end else if (n - tgo < REACT_MAX) begin
            leds = 0;                           flags = 3'b110;
        end else begin
            leds = 0;                           flags = 3'b001;
        end
        chk("leds", int'(sif.o_turnOnLED), leds);
        chk("go_busy_prbsEn", int'({sif.o_go, sif.o_busy, sif.o_prbsEn}), flags);
    endtask

    task automatic chk_reset();
        chk("rst_leds", int'(sif.o_turnOnLED), 0);
        chk("rst_flags go_busy_valid_false_timeout",
            int'({sif.o_go, sif.o_busy, sif.o_valid, sif.o_falseStart, sif.o_timeout}), 0);
        chk("rst_prbsEn", int'(sif.o_prbsEn), 1);
        chk("rst_reactionMs", int'(sif.o_reactionMs), 0);
        chk("rst_bestMs", int'(sif.o_bestMs), REACT_MAX);
    endtask

    // mode 0: no press; 1: press in the cycle of tick p; 2: press in a gap cycle after p ticks
    task automatic run_round(input int prbs, input int mode, input int p,
                             input bit stray, input bit start_press);
        int   tgo, n, n_eff;
        bit   t, pdo, sdo, pressed;
        exp_t e;
        tgo   = L_TICKS + DELAY_MIN + prbs;
        n_eff = (mode == 1) ? p - 1 : p;
        if (mode == 0 || n_eff - tgo >= REACT_MAX) begin
            e.kind  = K_TIMEOUT;
            m_react = REACT_MAX;
        end else if (n_eff < tgo) begin
            e.kind = K_FALSE;
        end else begin
            e.kind  = K_VALID;
            m_react = n_eff - tgo;
            if (m_react < m_best) m_best = m_react;
        end
        e.react = m_react;
        e.best  = m_best;
        q.push_back(e);

        sif.i_prbs = PRBS_W'(prbs);
        step(next_tick(), 1'b1, start_press);
        n       = 0;
        pressed = 1'b0;
        chk_state(0, tgo);
        while (!pressed && n < tgo + REACT_MAX) begin
            t   = next_tick();
            pdo = (mode == 1 && t && n + 1 == p) || (mode == 2 && !t && n == p);
            sdo = stray && !pdo && ($urandom_range(0, 5) == 0);
            step(t, sdo, pdo);
            if (t) n++;
            if (pdo) pressed = 1'b1;
            else     chk_state(n, tgo);
        end
        for (int i = 0; i < 4; i++) begin
            step(next_tick(), 1'b0, i == 1);
        end
    endtask

    // Result monitor: a round ends when busy drops
    always @(negedge clk) begin
        exp_t e;
        if (chk_valid_lo) begin
            chk("valid_single_cycle", int'(sif.o_valid), 0);
            chk_valid_lo = 1'b0;
        end
        if (busy_prev && !sif.o_busy && !abort) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got a round end, expected none at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("result_kind false_timeout", int'({sif.o_falseStart, sif.o_timeout}),
                    (e.kind == K_FALSE) ? 2 : (e.kind == K_TIMEOUT) ? 1 : 0);
                chk("valid_pulse", int'(sif.o_valid), (e.kind == K_VALID) ? 1 : 0);
                chk("reactionMs", int'(sif.o_reactionMs), e.react);
                chk("bestMs", int'(sif.o_bestMs), e.best);
                chk_valid_lo = 1'b1;
            end
        end
        busy_prev = sif.o_busy;
    end

    initial begin
        int prbs, sel, mode, p, tgo, n;
        bit t;
        sif.i_tick  = 1'b0;
        sif.i_start = 1'b0;
        sif.i_press = 1'b0;
        sif.i_prbs  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset();

        // directed rounds with i_prbs = 3 (go after 28 ticks)
        run_round(3, 2, 28 + 12, 1'b1, 1'b0);
        run_round(3, 2, 28 + 20, 1'b1, 1'b0);
        run_round(3, 2, 28 + 7,  1'b1, 1'b0);
        run_round(3, 2, 8,       1'b0, 1'b0);
        run_round(3, 2, 22,      1'b1, 1'b0);
        run_round(3, 0, 0,       1'b1, 1'b0);
        run_round(3, 1, 28 + 50, 1'b0, 1'b0);
        run_round(3, 1, 28,      1'b1, 1'b0);
        run_round(3, 2, 28 + 10, 1'b0, 1'b1);
        run_round(3, 1, 28 + 51, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            prbs = (r % 10 == 9) ? 255 : int'($urandom_range(0, 40));
            tgo  = L_TICKS + DELAY_MIN + prbs;
            sel  = int'($urandom_range(0, 9));
            mode = int'($urandom_range(1, 2));
            if (sel == 0) begin
                mode = 0;
                p    = 0;
            end else if (sel <= 3) begin
                p = int'($urandom_range(1, tgo - 1));
            end else begin
                p = tgo + int'($urandom_range(0, REACT_MAX + 1));
            end
            run_round(prbs, mode, p, 1'b1, $urandom_range(0, 3) == 0);
        end

        // reset in the middle of HOLD aborts the round
        sif.i_prbs = PRBS_W'(3);
        step(next_tick(), 1'b1, 1'b0);
        n = 0;
        while (n < 22) begin
            t = next_tick();
            step(t, 1'b0, 1'b0);
            if (t) n++;
        end
        chk_state(n, 28);
        abort = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset();
        repeat (2) @(negedge clk);
        abort = 1'b0;

        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
